// File: rtl/if_else_split_271_if.sv
// Handshake bundle for the if/else split stage: one combined input stream
// and two independently stallable per-branch output lanes.
interface if_else_split_271_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] input_bit;
  logic [31:0] segment_1_combine;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] segment_1_if;
  logic        else_valid;
  logic        else_ready;
  logic [31:0] segment_1_else;

  // Source of the combined stream and consumer of both lanes.
  modport master (
    output in_valid, input_bit, segment_1_combine, if_ready, else_ready,
    input  in_ready, if_valid, segment_1_if, else_valid, segment_1_else
  );

  // The split block itself.
  modport slave (
    input  in_valid, input_bit, segment_1_combine, if_ready, else_ready,
    output in_ready, if_valid, segment_1_if, else_valid, segment_1_else
  );
endinterface

// File: rtl/if_else_split_271.sv
// Steers each accepted combined-stream segment into a buffered if-lane or
// else-lane FIFO chosen by the masked branch condition; counts words per lane.
module if_else_split_271 #(
  parameter logic [31:0] COND_MASK = 32'h0000_0001,
  parameter int          DEPTH     = 4,
  parameter int          CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  if_else_split_271_if.slave  bus,
  output logic [CNT_W-1:0]    if_count,
  output logic [CNT_W-1:0]    else_count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LANES  = 2;
  localparam int L_IF   = 0;
  localparam int L_ELSE = 1;

  typedef logic [AW-1:0]    ptr_t;
  typedef logic [AW:0]      occ_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [31:0] mem    [LANES][DEPTH];
  ptr_t        wr_ptr [LANES];
  ptr_t        rd_ptr [LANES];
  occ_t        occ    [LANES];
  cnt_t        cnt    [LANES];

  logic             cond;
  logic             in_ready_int;
  logic             accept;
  logic [LANES-1:0] full;
  logic [LANES-1:0] push;
  logic [LANES-1:0] pop;
  logic [LANES-1:0] lane_ready;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cond         = |(bus.input_bit & COND_MASK);
    full         = '0;
    pop          = '0;
    lane_ready   = {bus.else_ready, bus.if_ready};
    for (int l = 0; l < LANES; l++) begin
      full[l] = (occ[l] == occ_t'(DEPTH));
      pop[l]  = (occ[l] != '0) && lane_ready[l];
    end
    // Ready depends only on registered occupancy, never on the offered word.
    in_ready_int = !full[L_IF] && !full[L_ELSE];
    accept       = bus.in_valid && in_ready_int;
    push         = '0;
    push[L_IF]   = accept && cond;
    push[L_ELSE] = accept && !cond;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        wr_ptr[l] <= '0;
        rd_ptr[l] <= '0;
        occ[l]    <= '0;
        cnt[l]    <= '0;
        // NOTE: storage is reset because the lane data outputs must read 0
        // out of reset; with DEPTH small this is a handful of flops.
        for (int d = 0; d < DEPTH; d++) mem[l][d] <= '0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (push[l]) begin
          mem[l][wr_ptr[l]] <= bus.segment_1_combine;
          wr_ptr[l]         <= wr_ptr[l] + ptr_t'(1);
          cnt[l]            <= cnt[l] + cnt_t'(1);
        end
        if (pop[l]) rd_ptr[l] <= rd_ptr[l] + ptr_t'(1);
        if (push[l] && !pop[l])      occ[l] <= occ[l] + occ_t'(1);
        else if (pop[l] && !push[l]) occ[l] <= occ[l] - occ_t'(1);
      end
    end
  end

  assign bus.in_ready       = in_ready_int;
  assign bus.if_valid       = (occ[L_IF] != '0);
  assign bus.else_valid     = (occ[L_ELSE] != '0);
  // Head entry is shown even when empty; it is stale there and don't-care.
  assign bus.segment_1_if   = mem[L_IF][rd_ptr[L_IF]];
  assign bus.segment_1_else = mem[L_ELSE][rd_ptr[L_ELSE]];
  assign if_count           = cnt[L_IF];
  assign else_count         = cnt[L_ELSE];

endmodule
